// File: rtl/btn_conditioner.sv
// Three-channel button conditioner: 2-flop synchroniser, saturating-counter debounce,
// registered level plus single-cycle rise/fall pulses per channel.
module btn_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:1] btn_raw,
   output logic [3:1] b,
   output logic [3:1] b_rise,
   output logic [3:1] b_fall,
   output logic       stable
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:1]       s1_q, s2_q;
   logic [CNT_W-1:0] cnt_q [3:1];
   logic [CNT_W-1:0] cnt_d [3:1];
   logic [3:1]       b_q, b_d;
   logic [3:1]       rise_q, rise_d;
   logic [3:1]       fall_q, fall_d;

   always_comb begin
      for (int i = 1; i <= 3; i++) begin
         cnt_d[i]  = '0;
         b_d[i]    = b_q[i];
         rise_d[i] = 1'b0;
         fall_d[i] = 1'b0;
         // Any sample that agrees with the accepted level restarts the count.
         if (s2_q[i] != b_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               b_d[i]    = s2_q[i];
               rise_d[i] = s2_q[i];
               fall_d[i] = ~s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q   <= '0;
         s2_q   <= '0;
         b_q    <= '0;
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 1; i <= 3; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q   <= btn_raw;
         s2_q   <= s1_q;
         b_q    <= b_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         for (int i = 1; i <= 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign b      = b_q;
   assign b_rise = rise_q;
   assign b_fall = fall_q;
   assign stable = &(~(s2_q ^ b_q));

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: stimulus pushes per-cycle expectations into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_btn_conditioner;

   localparam int DC = 4;

   typedef struct {
      int         cyc;
      string      tag;
      logic [3:1] b;
      logic [3:1] rise;
      logic [3:1] fall;
      logic       stable;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:1] btn_raw;
   logic [3:1] b, b_rise, b_fall;
   logic       stable;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t e;

   btn_conditioner #(
      .DEBOUNCE_CYCLES(DC),
      .CNT_W          (4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw),
      .b      (b),
      .b_rise (b_rise),
      .b_fall (b_fall),
      .stable (stable)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push(int c, string tag, logic [3:1] eb, logic [3:1] er,
                                logic [3:1] ef, logic es);
      exp_t x;
      x.cyc = c; x.tag = tag; x.b = eb; x.rise = er; x.fall = ef; x.stable = es;
      sb.push_back(x);
   endfunction

   function automatic void push_span(int c0, int c1, string tag, logic [3:1] eb, logic es);
      for (int c = c0; c <= c1; c++) push(c, tag, eb, 3'b000, 3'b000, es);
   endfunction

   // Clean change driven just after edge t0: captured at t0+1, accepted at t0+DC+2.
   function automatic void exp_change(int t0, string tag, logic [3:1] bo, logic [3:1] bn);
      push_span(t0 + 1, t0 + 1, tag, bo, 1'b1);
      push_span(t0 + 2, t0 + DC + 1, tag, bo, 1'b0);
      push(t0 + DC + 2, tag, bn, bn & ~bo, bo & ~bn, 1'b1);
      push_span(t0 + DC + 3, t0 + DC + 4, tag, bn, 1'b1);
   endfunction

   task automatic run(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         checks++;
         assert (e.cyc == cyc) else begin
            errors++;
            $error("FAIL %s.cycle got %0d want %0d", e.tag, cyc, e.cyc);
         end
         checks++;
         assert (b === e.b) else begin
            errors++;
            $error("FAIL %s.b cyc %0d got %b want %b", e.tag, cyc, b, e.b);
         end
         checks++;
         assert (b_rise === e.rise) else begin
            errors++;
            $error("FAIL %s.b_rise cyc %0d got %b want %b", e.tag, cyc, b_rise, e.rise);
         end
         checks++;
         assert (b_fall === e.fall) else begin
            errors++;
            $error("FAIL %s.b_fall cyc %0d got %b want %b", e.tag, cyc, b_fall, e.fall);
         end
         checks++;
         assert (stable === e.stable) else begin
            errors++;
            $error("FAIL %s.stable cyc %0d got %b want %b", e.tag, cyc, stable, e.stable);
         end
      end
   end

   initial begin
      int t0;
      rst     = 1'b1;
      btn_raw = 3'b111;
      push_span(1, 2, "reset", 3'b000, 1'b1);
      run(2);

      // Clean press on bit 1, released from reset at the same time.
      t0 = cyc;
      rst     = 1'b0;
      btn_raw = 3'b001;
      exp_change(t0, "press1", 3'b000, 3'b001);
      run(DC + 4);

      // Bounce on bit 2: high 3, low 1, then high steady.
      t0 = cyc;
      btn_raw = 3'b011;
      push_span(t0 + 1, t0 + 1, "bounce2", 3'b001, 1'b1);
      push_span(t0 + 2, t0 + 4, "bounce2", 3'b001, 1'b0);
      push_span(t0 + 5, t0 + 5, "bounce2", 3'b001, 1'b1);
      push_span(t0 + 6, t0 + 9, "bounce2", 3'b001, 1'b0);
      push(t0 + 10, "bounce2", 3'b011, 3'b010, 3'b000, 1'b1);
      push_span(t0 + 11, t0 + 12, "bounce2", 3'b011, 1'b1);
      run(3);
      btn_raw = 3'b001;
      run(1);
      btn_raw = 3'b011;
      run(8);

      // Simultaneous release of bits 1 and 2.
      t0 = cyc;
      btn_raw = 3'b000;
      exp_change(t0, "release12", 3'b011, 3'b000);
      run(DC + 4);

      // Simultaneous rise of bits 1 and 3.
      t0 = cyc;
      btn_raw = 3'b101;
      exp_change(t0, "rise13", 3'b000, 3'b101);
      run(DC + 4);

      // Release bit 3 only.
      t0 = cyc;
      btn_raw = 3'b001;
      exp_change(t0, "release3", 3'b101, 3'b001);
      run(DC + 4);

      // Short pulse on bit 3: three captured high samples, one short of acceptance.
      t0 = cyc;
      btn_raw = 3'b101;
      push_span(t0 + 1, t0 + 1, "short3", 3'b001, 1'b1);
      push_span(t0 + 2, t0 + 4, "short3", 3'b001, 1'b0);
      push_span(t0 + 5, t0 + 8, "short3", 3'b001, 1'b1);
      run(3);
      btn_raw = 3'b000 | 3'b001;
      run(5);

      // Release bit 1 so the reset-mid-count case starts from b = 0.
      t0 = cyc;
      btn_raw = 3'b000;
      exp_change(t0, "release1", 3'b001, 3'b000);
      run(DC + 4);

      // Bit 1 held high, reset lands while the count sits at 2.
      t0 = cyc;
      btn_raw = 3'b001;
      push_span(t0 + 1, t0 + 1, "rstmid", 3'b000, 1'b1);
      push_span(t0 + 2, t0 + 4, "rstmid", 3'b000, 1'b0);
      push_span(t0 + 5, t0 + 6, "rstmid", 3'b000, 1'b1);
      exp_change(t0 + 6, "rstmid_after", 3'b000, 3'b001);
      run(4);
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      run(DC + 4);

      @(negedge clk);
      #1;
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL drain got %0d pending want 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Upstream input stage for the 3-bit `b[3:1]` sequence-detector state machine. Takes three asynchronous, bouncy push-button/switch inputs, synchronises each into the `clk` domain, and debounces it with a per-channel saturating counter. Outputs a clean level per channel plus single-cycle rise/fall pulses. The `b` output connects directly to the state machine's `b` input.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable synchronised samples required to accept a new level; legal range 1..2^CNT_W.
- `CNT_W`, default 16: width of each per-channel debounce counter.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `btn_raw`  input  [3:1]  asynchronous raw button/switch levels.
- `b`  output  [3:1]  debounced level, registered.
- `b_rise`  output  [3:1]  one-cycle pulse in the cycle `b[i]` goes 0→1, registered.
- `b_fall`  output  [3:1]  one-cycle pulse in the cycle `b[i]` goes 1→0, registered.
- `stable`  output  1  high when no channel has a pending change, i.e. synchronised input equals `b` on all three bits.

## Operation

- Each channel i in 1..3 is independent and identical. There is no cross-channel coupling except `stable`.
- Synchroniser: two flops per bit. `s1[i] <= btn_raw[i]`, `s2[i] <= s1[i]`. Only `s2` feeds the debounce logic.
- Debounce per channel, evaluated every edge when `rst` = 0:
  - `s2[i] == b[i]`: `cnt[i] <= 0`. No output change.
  - `s2[i] != b[i]` and `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i] <= cnt[i]+1`.
  - `s2[i] != b[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `b[i] <= s2[i]` and `cnt[i] <= 0`. Pulse `b_rise[i]` or `b_fall[i]` according to the new value.
- The counter never wraps; it clears on acceptance or on any agreeing sample.
- A glitch that returns to the current `b[i]` before the threshold clears the count. `b[i]` is untouched and no pulse is produced.
- `b_rise` and `b_fall` are low in every cycle other than the one immediately after an accepting edge. They are never both high on the same bit.
- `stable` = AND over i of (`s2[i] == b[i]`). It is combinational from registers and has no glitch path from `btn_raw`.
- Reset (`rst` = 1 at a rising edge) clears `s1`, `s2`, `cnt`, `b`, `b_rise` and `b_fall` to 0. This applies regardless of in-progress counts.

## Timing

- Reset values: `b` = 3'b000, `b_rise` = 3'b000, `b_fall` = 3'b000, `stable` = 1.
- Let E0 be the first edge at which `s1[i]` captures a new raw level that is then held steady.
  - `s2[i]` changes at E1.
  - Debounce comparisons start at E2.
  - `b[i]` and the pulse update at edge E(1+DEBOUNCE_CYCLES).
  - Total latency from E0 is DEBOUNCE_CYCLES+1 edges.
  - Example: DEBOUNCE_CYCLES = 1 gives `b` updating at E2.
- The pulse is high for exactly one cycle, aligned with the first cycle of the new `b` level.
- `stable` falls in the cycle after E1 and returns high in the same cycle `b` updates.
- Simultaneous changes on several bits that are captured at the same edge update their `b` bits at the same edge, with one pulse per bit.
- A raw level held through reset release is treated as a new change. E0 is the first edge with `rst` = 0.
- A raw pulse that yields fewer than DEBOUNCE_CYCLES consecutive differing `s2` samples is fully rejected.

## Test plan

Run with DEBOUNCE_CYCLES = 4 and CNT_W = 4.

1. Reset: `rst` = 1 for 2 edges with `btn_raw` = 3'b111. Required: `b` = 0, `b_rise` = `b_fall` = 0, `stable` = 1 throughout reset.
2. Clean press: `btn_raw[1]` 0→1 captured at E0, held. Required:
   - `b[1]` = 1 and `b_rise[1]` = 1 after E5; `b_rise[1]` is 0 after E6.
   - `b[3:2]` stays 0.
   - `stable` is 0 from E1 to E5.
3. Bounce: `btn_raw[2]` high 3 cycles, low 1, then high steady. Required:
   - No change on `b[2]` until 5 edges after the final rising capture.
   - Exactly one `b_rise[2]` pulse and zero `b_fall[2]` pulses.
4. Simultaneous events: `btn_raw[1]` and `btn_raw[3]` rise at the same edge. Required: `b` = 3'b101 with `b_rise` = 3'b101 on the same cycle. Then release bit 3 only. Required: `b_fall` = 3'b100 once, `b[1]` stays 1.
5. Short pulse: `btn_raw[3]` high for exactly 3 captured cycles. Required: `b[3]` stays 0, no pulses, `stable` returns to 1.
6. Reset mid-count: `btn_raw[1]` held high, `rst` asserted when `cnt[1]` = 2. Required:
   - `b[1]` stays 0.
   - After release, `b[1]` rises 5 edges after the first post-reset edge, with one `b_rise[1]` pulse.
